vga_scanout: RTL and testbench



---
 rtl/vga_scanout_if.sv | 10 +
 rtl/vga_scanout.sv | 161 ++++++++++++++++
 tb/tb_vga_scanout.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Video memory read port between the scan-out engine and data memory.
// The address is combinational from the engine's registers; read data
// returns one clock later, bytes packed little-endian.
interface vga_scanout_if;
  logic [31:0] vmem_addr;
  logic [31:0] vmem_rdata;

  modport master (output vmem_addr, input  vmem_rdata);
  modport slave  (input  vmem_addr, output vmem_rdata);
endinterface

// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out engine. Derives the 25 MHz pixel rate from the
// 100 MHz clock with a 2-bit phase counter, fetches RGB332 framebuffer
// bytes (160x120, each drawn as a 4x4 block) and expands them to 8 bits per
// channel. Pins are registered on the pixel-enable edge, so they lag the
// counters by one pixel period. The framebuffer base switches only at the
// end of the last visible line.
module vga_scanout #(
  parameter logic [31:0] FB_BASE0 = 32'h0000_1000,
  parameter logic [31:0] FB_BASE1 = 32'h0000_6000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fb_sel,
  vga_scanout_if.master        vmem,
  output logic                 frame_done,
  output logic                 vgaclk,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 sync_b,
  output logic                 blank_b,
  output logic [7:0]           r,
  output logic [7:0]           g,
  output logic [7:0]           b
);

  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd751;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] V_LAST_VIS = 10'd479;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd491;

  // 3-bit channel to 8 bits: replicate, then fill with the top two bits
  function automatic logic [7:0] expand3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  // 2-bit channel to 8 bits by plain replication
  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  logic [1:0]  ph_q, ph_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [31:0] base_q, base_d;
  logic        frame_done_q, frame_done_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        sync_b_q, sync_b_d;
  logic        blank_b_q, blank_b_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  g_q, g_d;
  logic [7:0]  b_q, b_d;

  logic        pix_en;
  logic        visible;
  logic        frame_end;
  logic [31:0] y_w;
  logic [7:0]  pix_byte;

  // Timing counters, frame-end detection and base selection
  always_comb begin
    pix_en    = (ph_q == 2'd3);
    visible   = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    frame_end = pix_en && (hcnt_q == H_LAST) && (vcnt_q == V_LAST_VIS);
    ph_d      = ph_q + 2'd1;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = 10'd0;
        vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
    base_d       = frame_end ? (fb_sel ? FB_BASE1 : FB_BASE0) : base_q;
    frame_done_d = frame_end;
  end

  // Word address: base + y*160 + x rounded down to a word; base alone in blanking
  always_comb begin
    y_w = {24'd0, vcnt_q[9:2]};
    if (visible)
      vmem.vmem_addr = base_q + (y_w << 7) + (y_w << 5) + {24'd0, hcnt_q[9:4], 2'b00};
    else
      vmem.vmem_addr = base_q;
  end

  // Byte lane select and next pin values, committed only on pixel enable
  always_comb begin
    case (hcnt_q[3:2])
      2'd0:    pix_byte = vmem.vmem_rdata[7:0];
      2'd1:    pix_byte = vmem.vmem_rdata[15:8];
      2'd2:    pix_byte = vmem.vmem_rdata[23:16];
      default: pix_byte = vmem.vmem_rdata[31:24];
    endcase
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    sync_b_d  = sync_b_q;
    blank_b_d = blank_b_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    if (pix_en) begin
      hsync_d   = !((hcnt_q >= H_SYNC_LO) && (hcnt_q <= H_SYNC_HI));
      vsync_d   = !((vcnt_q >= V_SYNC_LO) && (vcnt_q <= V_SYNC_HI));
      sync_b_d  = hsync_d & vsync_d;
      blank_b_d = visible;
      r_d       = visible ? expand3(pix_byte[7:5]) : 8'd0;
      g_d       = visible ? expand3(pix_byte[4:2]) : 8'd0;
      b_d       = visible ? expand2(pix_byte[1:0]) : 8'd0;
    end
  end

  // State registers; reset restarts the scan at pixel (0,0) on framebuffer 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q         <= 2'd0;
      hcnt_q       <= 10'd0;
      vcnt_q       <= 10'd0;
      base_q       <= FB_BASE0;
      frame_done_q <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      sync_b_q     <= 1'b1;
      blank_b_q    <= 1'b0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      b_q          <= 8'd0;
    end else begin
      ph_q         <= ph_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      base_q       <= base_d;
      frame_done_q <= frame_done_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      sync_b_q     <= sync_b_d;
      blank_b_q    <= blank_b_d;
      r_q          <= r_d;
      g_q          <= g_d;
      b_q          <= b_d;
    end
  end

  assign vgaclk     = ph_q[1];
  assign frame_done = frame_done_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign sync_b     = sync_b_q;
  assign blank_b    = blank_b_q;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a timing model driven by the count of clock edges
// since reset release predicts every output each cycle; directed literal
// checks pin the model at hand-computed points.
module tb_vga_scanout;

  localparam logic [31:0] MEM_WORD = 32'hE01C_03FF;
  localparam int PIX_PER_FRAME = 420000;
  localparam int LAST_VIS_PIX  = 479 * 800 + 799;

  logic        clk = 1'b0;
  logic        reset;
  logic        fb_sel;
  logic        frame_done, vgaclk, hsync, vsync, sync_b, blank_b;
  logic [7:0]  r, g, b;

  vga_scanout_if vmem ();

  vga_scanout #(
    .FB_BASE0(32'h0000_1000),
    .FB_BASE1(32'h0000_6000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fb_sel     (fb_sel),
    .vmem       (vmem),
    .frame_done (frame_done),
    .vgaclk     (vgaclk),
    .hsync      (hsync),
    .vsync      (vsync),
    .sync_b     (sync_b),
    .blank_b    (blank_b),
    .r          (r),
    .g          (g),
    .b          (b)
  );

  always #5 clk = ~clk;

  // Memory: constant word, one clock of latency
  always @(posedge clk) vmem.vmem_rdata <= MEM_WORD;

  int          k;
  logic [31:0] base_m;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, k);
      if (n_fail >= 100) begin
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  endtask

  // Edge counter since reset release and model of the active base
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0;
      base_m = 32'h0000_1000;
    end else begin
      if (((k + 1) % 4 == 0) && (((k + 1) / 4 - 1) % PIX_PER_FRAME == LAST_VIS_PIX))
        base_m = fb_sel ? 32'h0000_6000 : 32'h0000_1000;
      k = k + 1;
    end
  end

  function automatic logic [7:0] exp3(input int c);
    return 8'((c << 5) | (c << 2) | (c >> 1));
  endfunction

  function automatic logic [23:0] exp_rgb(input int hp, input int vp);
    int lane;
    int p;
    if (!(hp < 640 && vp < 480)) return 24'd0;
    lane = (hp / 4) % 4;
    p = int'((MEM_WORD >> (8 * lane)) & 32'hFF);
    return {exp3(p / 32), exp3((p / 4) % 8), 8'((p % 4) * 85)};
  endfunction

  int          m_n, m_c, m_h, m_v, m_q, m_hp, m_vp;
  logic [31:0] m_addr;
  logic [5:0]  m_ctl;
  logic [23:0] m_rgb;
  logic        m_hs, m_vs, m_fd;

  // Per-cycle comparison against the timing model
  always @(negedge clk) begin
    m_n = k / 4;
    m_c = m_n % PIX_PER_FRAME;
    m_h = m_c % 800;
    m_v = m_c / 800;
    if (m_h < 640 && m_v < 480)
      m_addr = base_m + 32'((m_v / 4) * 160 + (m_h / 16) * 4);
    else
      m_addr = base_m;
    if (m_n == 0) begin
      m_ctl = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      m_rgb = 24'd0;
    end else begin
      m_q  = (m_n - 1) % PIX_PER_FRAME;
      m_hp = m_q % 800;
      m_vp = m_q / 800;
      m_hs = !(m_hp >= 656 && m_hp <= 751);
      m_vs = !(m_vp >= 490 && m_vp <= 491);
      m_fd = (k % 4 == 0) && (m_q == LAST_VIS_PIX);
      m_ctl = {m_hs, m_vs, m_hs & m_vs, (m_hp < 640 && m_vp < 480), m_fd, 1'b0};
      m_rgb = exp_rgb(m_hp, m_vp);
    end
    m_ctl[0] = (k % 4) >= 2;
    check("model_ctl", {26'd0, hsync, vsync, sync_b, blank_b, frame_done, vgaclk}, {26'd0, m_ctl});
    check("model_rgb", {8'd0, r, g, b}, {8'd0, m_rgb});
    check("model_addr", vmem.vmem_addr, m_addr);
  end

  task automatic wait_k(input int t);
    while (k < t) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    fb_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {26'd0, hsync, vsync, sync_b, blank_b, frame_done, vgaclk}, 32'b111000);
    check("rst_rgb", {8'd0, r, g, b}, 32'd0);
    check("rst_addr", vmem.vmem_addr, 32'h0000_1000);
    reset = 1'b0;

    wait_k(3);
    check("edge3_pins", {27'd0, hsync, vsync, sync_b, blank_b, frame_done}, 32'b11100);
    check("edge3_rgb", {8'd0, r, g, b}, 32'd0);
    wait_k(4);
    check("edge4_blank", {31'd0, blank_b}, 32'd1);
    check("lane0_rgb", {8'd0, r, g, b}, 32'h00FF_FFFF);
    wait_k(20);
    check("lane1_rgb", {8'd0, r, g, b}, 32'h0000_00FF);
    wait_k(36);
    check("lane2_rgb", {8'd0, r, g, b}, 32'h0000_FF00);
    wait_k(52);
    check("lane3_rgb", {8'd0, r, g, b}, 32'h00FF_0000);

    wait_k(2627);
    check("hsync_before_fall", {31'd0, hsync}, 32'd1);
    wait_k(2628);
    check("hsync_fall", {31'd0, hsync}, 32'd0);
    wait_k(3011);
    check("hsync_last_low", {31'd0, hsync}, 32'd0);
    wait_k(3012);
    check("hsync_rise", {31'd0, hsync}, 32'd1);

    wait_k(28880);
    check("addr_x5_y2", vmem.vmem_addr, 32'h0000_1144);

    wait_k(320000);
    fb_sel = 1'b1;
    wait_k(1532800);
    check("addr_line479_base0", vmem.vmem_addr, 32'h0000_5A60);
    wait_k(1535999);
    check("fd_before", {31'd0, frame_done}, 32'd0);
    wait_k(1536000);
    check("fd_pulse", {31'd0, frame_done}, 32'd1);
    wait_k(1536001);
    check("fd_after", {31'd0, frame_done}, 32'd0);

    wait_k(1568003);
    check("vsync_before_fall", {31'd0, vsync}, 32'd1);
    wait_k(1568004);
    check("vsync_fall", {31'd0, vsync}, 32'd0);
    wait_k(1574403);
    check("vsync_last_low", {31'd0, vsync}, 32'd0);
    wait_k(1574404);
    check("vsync_rise", {31'd0, vsync}, 32'd1);

    wait_k(1680000);
    check("frame1_first_addr", vmem.vmem_addr, 32'h0000_6000);

    wait_k(2321202);
    check("pre_rst_vgaclk", {31'd0, vgaclk}, 32'd1);
    check("pre_rst_rgb", {8'd0, r, g, b}, 32'h0000_FF00);
    #1 reset = 1'b1;
    #1;
    check("midrst_ctl", {26'd0, hsync, vsync, sync_b, blank_b, frame_done, vgaclk}, 32'b111000);
    check("midrst_rgb", {8'd0, r, g, b}, 32'd0);
    check("midrst_addr", vmem.vmem_addr, 32'h0000_1000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    wait_k(4);
    check("restart_blank", {31'd0, blank_b}, 32'd1);
    check("restart_rgb", {8'd0, r, g, b}, 32'h00FF_FFFF);
    wait_k(28880);
    check("restart_addr_base0", vmem.vmem_addr, 32'h0000_1144);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
